// File: rtl/tanh_layer_sequencer.sv
// Streams a latched vector of half-precision elements through an external tanh core one at a time
// and reassembles the results. An element the core never finishes is replaced by qNaN.
module tanh_layer_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_ELEMS  = 24,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [DATA_WIDTH*NUM_ELEMS-1:0]  data_in_i,
  output logic [DATA_WIDTH*NUM_ELEMS-1:0]  data_out_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o,
  output logic [DATA_WIDTH-1:0]            core_x_o,
  output logic                             core_reset_o,
  input  logic [DATA_WIDTH-1:0]            core_out_i,
  input  logic                             core_finished_i
);

  localparam int unsigned IdxW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_ELEMS - 1);
  localparam logic [CntW-1:0]       LastCnt = CntW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] QNaN    = DATA_WIDTH'(16'h7E00);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] vec_q [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] out_q [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] out_d [NUM_ELEMS];
  logic                  vec_load;
  logic                  elem_done;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    out_d        = out_q;
    vec_load     = 1'b0;
    elem_done    = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    core_reset_o = 1'b1;
    core_x_o     = '0;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        if (start_i) begin
          vec_load = 1'b1;
          idx_d    = '0;
          error_d  = 1'b0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        core_x_o = vec_q[idx_q];
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        core_x_o     = vec_q[idx_q];
        core_reset_o = 1'b0;
        if (core_finished_i) begin
          out_d[idx_q] = core_out_i;
          elem_done    = 1'b1;
        end else if (cnt_q == LastCnt) begin
          out_d[idx_q] = QNaN;
          error_d      = 1'b1;
          elem_done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (elem_done) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        vec_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      out_q   <= out_d;
      if (vec_load) begin
        for (int i = 0; i < NUM_ELEMS; i++) begin
          vec_q[i] <= data_in_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign error_o = error_q;

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_pack
    assign data_out_o[g*DATA_WIDTH +: DATA_WIDTH] = out_q[g];
  end

endmodule
